// File: rtl/itu_656_encoder_pkg.sv
// itu656_pkg: shared BT.656 constants, the protected XY timing-code function and
// the 75% colour-bar table used by itu_656_encoder (bars only with ITU656_COLORBAR_EN).
package itu656_pkg;

  localparam int H_W = 11;
  localparam int V_W = 10;

  localparam logic [7:0] PRE_FF     = 8'hFF;
  localparam logic [7:0] PRE_00     = 8'h00;
  localparam logic [7:0] BLANK_EVEN = 8'h80;
  localparam logic [7:0] BLANK_ODD  = 8'h10;
  localparam logic [7:0] CLIP_LO    = 8'h01;
  localparam logic [7:0] CLIP_HI    = 8'hFE;

  // White, yellow, cyan, green, magenta, red, blue, black at 75% amplitude.
  localparam logic [7:0] BAR_Y  [8] = '{8'hB4, 8'hA2, 8'h83, 8'h70, 8'h54, 8'h41, 8'h23, 8'h10};
  localparam logic [7:0] BAR_CB [8] = '{8'h80, 8'h2C, 8'h9C, 8'h48, 8'hB8, 8'h64, 8'hD4, 8'h80};
  localparam logic [7:0] BAR_CR [8] = '{8'h80, 8'h8E, 8'h2C, 8'h3A, 8'hC6, 8'hD4, 8'h72, 8'h80};

  function automatic logic [7:0] xy_code(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

endpackage

// File: rtl/itu_656_encoder_if.sv
// itu_656_encoder_if: 4:2:2 sample handshake between a YCbCr source (master)
// and the BT.656 encoder (slave).
interface itu_656_encoder_if;

  logic [15:0] iYCbCr;
  logic        iDVAL;
  logic        oReady;

  modport master (output iYCbCr, output iDVAL, input oReady);
  modport slave  (input iYCbCr, input iDVAL, output oReady);

endinterface

// File: rtl/itu_656_encoder_timing.sv
// itu656_timing: free-running BT.656 byte/line counters and the region flags
// (EAV, SAV, active, F, V, start-of-frame) decoded from them.
module itu656_timing
  import itu656_pkg::*;
#(
  parameter int H_BYTES_TOTAL  = 1716,
  parameter int H_ACTIVE_BYTES = 1440,
  parameter int V_LINES_TOTAL  = 525,
  parameter int F2_START       = 263,
  parameter int V1_ACT_START   = 20,
  parameter int V2_ACT_START   = 283
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic [1:0]     code_idx,
`ifdef ITU656_COLORBAR_EN
  output logic [H_W-1:0] act_idx,
`endif
  output logic           h_odd,
  output logic           eav,
  output logic           sav,
  output logic           active,
  output logic           blank_h,
  output logic           f,
  output logic           v,
  output logic           sof
);

  localparam logic [H_W-1:0] H_LAST    = H_W'(H_BYTES_TOTAL - 1);
  localparam logic [H_W-1:0] SAV_START = H_W'(H_BYTES_TOTAL - H_ACTIVE_BYTES - 4);
  localparam logic [H_W-1:0] ACT_START = H_W'(H_BYTES_TOTAL - H_ACTIVE_BYTES);
  localparam logic [1:0]     SAV_PH    = SAV_START[1:0];
  localparam logic [V_W-1:0] V_LAST    = V_W'(V_LINES_TOTAL - 1);
  localparam logic [V_W-1:0] F2_LINE   = V_W'(F2_START);
  localparam logic [V_W-1:0] V1_LINE   = V_W'(V1_ACT_START);
  localparam logic [V_W-1:0] V2_LINE   = V_W'(V2_ACT_START);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
    end else begin
      h_cnt <= h_cnt + H_W'(1);
    end
  end

  assign h_odd   = h_cnt[0];
  assign eav     = (h_cnt < H_W'(4));
  assign sav     = (h_cnt >= SAV_START) && (h_cnt < ACT_START);
  assign active  = (h_cnt >= ACT_START);
  assign blank_h = (h_cnt < ACT_START);
  // Byte position inside the 4-byte FF 00 00 XY sequence of either code.
  assign code_idx = eav ? h_cnt[1:0] : h_cnt[1:0] - SAV_PH;
  assign f       = (v_cnt >= F2_LINE);
  assign v       = (v_cnt < V1_LINE) || (f && (v_cnt < V2_LINE));
  assign sof     = (h_cnt == '0) && (v_cnt == '0);

`ifdef ITU656_COLORBAR_EN
  assign act_idx = h_cnt - ACT_START;
`endif

endmodule

// File: rtl/itu_656_encoder.sv
// itu_656_encoder: BT.656 byte-stream transmitter (timing codes, blanking fill, 4:2:2 payload).
// Define ITU656_COLORBAR_EN to add the iPattern input and the internal 75% colour-bar source.
module itu_656_encoder
  import itu656_pkg::*;
#(
  parameter int H_BYTES_TOTAL  = 1716,
  parameter int H_ACTIVE_BYTES = 1440,
  parameter int V_LINES_TOTAL  = 525,
  parameter int F2_START       = 263,
  parameter int V1_ACT_START   = 20,
  parameter int V2_ACT_START   = 283
) (
  input  logic             iCLK,
  input  logic             iRST_N,
`ifdef ITU656_COLORBAR_EN
  input  logic             iPattern,
`endif
  itu_656_encoder_if.slave sif,
  output logic [7:0]       oTD_DATA,
  output logic             oF,
  output logic             oV,
  output logic             oH,
  output logic             oSOF,
  output logic             oUnderflow
);

  logic [1:0] code_idx;
  logic       h_odd, eav, sav, active, blank_h, f, v, sof;
  logic       pat_on, ready, starve;
  logic [7:0] y_p0;
  logic [7:0] bar_byte;
  logic [7:0] byte_nxt;

  function automatic logic [7:0] clip_byte(input logic [7:0] b);
    if (b == 8'h00) return CLIP_LO;
    if (b == 8'hFF) return CLIP_HI;
    return b;
  endfunction

  itu656_timing #(
    .H_BYTES_TOTAL (H_BYTES_TOTAL),
    .H_ACTIVE_BYTES(H_ACTIVE_BYTES),
    .V_LINES_TOTAL (V_LINES_TOTAL),
    .F2_START      (F2_START),
    .V1_ACT_START  (V1_ACT_START),
    .V2_ACT_START  (V2_ACT_START)
  ) u_timing (
    .clk     (iCLK),
    .rst_n   (iRST_N),
    .code_idx(code_idx),
`ifdef ITU656_COLORBAR_EN
    .act_idx (act_idx),
`endif
    .h_odd   (h_odd),
    .eav     (eav),
    .sav     (sav),
    .active  (active),
    .blank_h (blank_h),
    .f       (f),
    .v       (v),
    .sof     (sof)
  );

`ifdef ITU656_COLORBAR_EN
  localparam int BAR_W = H_ACTIVE_BYTES / 8;

  logic [H_W-1:0] act_idx;
  logic [2:0]     bar;

  assign pat_on = iPattern;

  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (act_idx >= H_W'(i * BAR_W)) bar = 3'(i);
    end
    case (act_idx[1:0])
      2'd0:    bar_byte = BAR_CB[bar];
      2'd2:    bar_byte = BAR_CR[bar];
      default: bar_byte = BAR_Y[bar];
    endcase
  end
`else
  assign pat_on   = 1'b0;
  assign bar_byte = BLANK_EVEN;
`endif

  // Samples are taken only on the C slot of an active line; the Y slot replays y_p0.
  assign ready      = active & ~v & ~h_odd & ~pat_on;
  assign starve     = ready & ~sif.iDVAL;
  assign sif.oReady = ready;

  always_comb begin
    byte_nxt = h_odd ? BLANK_ODD : BLANK_EVEN;
    if (eav || sav) begin
      case (code_idx)
        2'd0:    byte_nxt = PRE_FF;
        2'd3:    byte_nxt = xy_code(f, v, eav);
        default: byte_nxt = PRE_00;
      endcase
    end else if (active && !v) begin
      if (pat_on)
        byte_nxt = clip_byte(bar_byte);
      else if (!h_odd)
        byte_nxt = sif.iDVAL ? clip_byte(sif.iYCbCr[7:0]) : BLANK_EVEN;
      else
        byte_nxt = clip_byte(y_p0);
    end
  end

  // p0: Y half of the accepted sample (or the odd fill byte when starved)
  always_ff @(posedge iCLK) begin
    if (ready) y_p0 <= sif.iDVAL ? sif.iYCbCr[15:8] : BLANK_ODD;
  end

  // p1: registered byte stream and flags
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oTD_DATA   <= BLANK_EVEN;
      oF         <= 1'b0;
      oV         <= 1'b1;
      oH         <= 1'b1;
      oSOF       <= 1'b0;
      oUnderflow <= 1'b0;
    end else begin
      oTD_DATA <= byte_nxt;
      oF       <= f;
      oV       <= v;
      oH       <= blank_h;
      oSOF     <= sof;
      if (starve) oUnderflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_itu_656_encoder.sv
`timescale 1ns/1ps
// tb_itu_656_encoder: scoreboard bench for the BT.656 encoder, using full 1716-byte
// lines and a shortened 13-line frame (field 2 at line 7, active from lines 2 and 9).
module tb_itu_656_encoder;

  localparam int HT   = 1716;
  localparam int HA   = 1440;
  localparam int VL   = 13;
  localparam int F2   = 7;
  localparam int V1A  = 2;
  localparam int V2A  = 9;
  localparam int SAVS = HT - HA - 4;
  localparam int ACTS = HT - HA;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b1;
  logic [7:0] oTD_DATA;
  logic       oF, oV, oH, oSOF, oUnderflow;

  itu_656_encoder_if sif();

  itu_656_encoder #(
    .H_BYTES_TOTAL (HT),
    .H_ACTIVE_BYTES(HA),
    .V_LINES_TOTAL (VL),
    .F2_START      (F2),
    .V1_ACT_START  (V1A),
    .V2_ACT_START  (V2A)
  ) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
`ifdef ITU656_COLORBAR_EN
    .iPattern  (1'b0),
`endif
    .sif       (sif),
    .oTD_DATA  (oTD_DATA),
    .oF        (oF),
    .oV        (oV),
    .oH        (oH),
    .oSOF      (oSOF),
    .oUnderflow(oUnderflow)
  );

  always #5 iCLK = ~iCLK;

  int         checks = 0;
  int         errors = 0;
  int         cyc;
  int         acc;
  int         drop_line;
  int         drop_samp;
  logic       c_tog;
  logic       clip_mode;
  logic [7:0] sb[$];

  function automatic logic vexp(int ln);
    return (ln < V1A) || (ln >= F2 && ln < V2A);
  endfunction

  function automatic logic [7:0] clip8(logic [7:0] b);
    if (b == 8'h00) return 8'h01;
    if (b == 8'hFF) return 8'hFE;
    return b;
  endfunction

  // Expected byte for timing codes and fill (everything except active-line payload).
  function automatic logic [7:0] exp_ctl(int h, int ln);
    logic f, v, hb;
    int   k;
    f = (ln >= F2);
    v = vexp(ln);
    if (h < 4 || (h >= SAVS && h < ACTS)) begin
      hb = (h < 4);
      k  = hb ? h : h - SAVS;
      if (k == 0) return 8'hFF;
      if (k == 3) return {1'b1, f, v, hb, v ^ hb, f ^ hb, f ^ v, f ^ v ^ hb};
      return 8'h00;
    end
    return (h % 2 == 0) ? 8'h80 : 8'h10;
  endfunction

  task automatic step();
    @(posedge iCLK);
    #1;
    cyc++;
  endtask

  task automatic clear_model();
    sb.delete();
    c_tog = 1'b0;
    acc   = 0;
    cyc   = 0;
  endtask

  task automatic apply_reset();
    iRST_N        = 1'b0;
    sif.iDVAL     = 1'b0;
    sif.iYCbCr    = '0;
    drop_line     = -1;
    drop_samp     = -1;
    clip_mode     = 1'b0;
    clear_model();
    repeat (3) @(posedge iCLK);
    #1 iRST_N = 1'b1;
  endtask

  // Drive the source for the coming edge and push the bytes the accepted/starved slot must produce.
  task automatic drive_src();
    int         hn, ln, samp;
    logic       dv;
    logic [7:0] y, c;
    hn   = cyc % HT;
    ln   = (cyc / HT) % VL;
    samp = (hn - ACTS) / 2;
    dv   = !(hn >= ACTS && ln == drop_line && samp == drop_samp);
    y    = clip_mode ? 8'hFF : 8'h50;
    c    = clip_mode ? 8'h00 : (c_tog ? 8'h90 : 8'h30);
    sif.iDVAL  = dv;
    sif.iYCbCr = {y, c};
    if (sif.oReady === 1'b1) begin
      if (dv) begin
        sb.push_back(clip8(c));
        sb.push_back(clip8(y));
        c_tog = !c_tog;
        acc++;
      end else begin
        sb.push_back(8'h80);
        sb.push_back(8'h10);
      end
    end
  endtask

  task automatic test_reset();
    @(posedge iCLK);
    #1 iRST_N = 1'b0;
    sif.iDVAL  = 1'b0;
    sif.iYCbCr = '0;
    #1;
    checks++; if (oTD_DATA !== 8'h80) begin errors++; $display("FAIL reset_data got %h want 80", oTD_DATA); end
    checks++; if ({oF, oV, oH, oSOF} !== 4'b0110) begin errors++; $display("FAIL reset_flags FVHS got %b want 0110", {oF, oV, oH, oSOF}); end
    checks++; if (sif.oReady !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", sif.oReady); end
    checks++; if (oUnderflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b want 0", oUnderflow); end
    repeat (2) @(posedge iCLK);
    #1 iRST_N = 1'b1;
    clear_model();
    drop_line = -1;
    drop_samp = -1;
    clip_mode = 1'b0;
    step();
    checks++; if (oTD_DATA !== 8'hFF) begin errors++; $display("FAIL reset_first_byte got %h want FF", oTD_DATA); end
    checks++; if (oSOF !== 1'b1) begin errors++; $display("FAIL reset_first_sof got %b want 1", oSOF); end
  endtask

  task automatic test_frame();
    int         b, h, ln, sof_n, sof_first, sof_second, act_lines;
    logic [7:0] exp;
    logic [7:0] cap [5];
    logic       rdy_exp;
    sof_n = 0; sof_first = -1; sof_second = -1; act_lines = 0;
    foreach (cap[i]) cap[i] = 8'h00;
    apply_reset();
    for (int n = 0; n < VL * HT + 1; n++) begin
      h = cyc % HT;
      ln = (cyc / HT) % VL;
      rdy_exp = (h >= ACTS) && !vexp(ln) && (h % 2 == 0);
      drive_src();
      checks++;
      if (sif.oReady !== rdy_exp) begin errors++; $display("FAIL frame_ready line %0d byte %0d got %b want %b", ln, h, sif.oReady, rdy_exp); end
      step();
      b = cyc - 1; h = b % HT; ln = (b / HT) % VL;
      if (h >= ACTS && !vexp(ln)) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL frame_sb_empty line %0d byte %0d got %h want queued byte", ln, h, oTD_DATA); end
        else begin
          exp = sb.pop_front();
          if (oTD_DATA !== exp) begin errors++; $display("FAIL frame_active line %0d byte %0d got %h want %h", ln, h, oTD_DATA, exp); end
        end
      end else begin
        exp = exp_ctl(h, ln);
        checks++;
        if (oTD_DATA !== exp) begin errors++; $display("FAIL frame_ctl line %0d byte %0d got %h want %h", ln, h, oTD_DATA, exp); end
      end
      checks++;
      if ({oF, oV, oH, oSOF} !== {ln >= F2, vexp(ln), h < ACTS, b % (VL * HT) == 0}) begin
        errors++;
        $display("FAIL frame_flags line %0d byte %0d FVHS got %b want %b", ln, h, {oF, oV, oH, oSOF}, {ln >= F2, vexp(ln), h < ACTS, b % (VL * HT) == 0});
      end
      if (oSOF === 1'b1) begin
        sof_n++;
        if (sof_first < 0) sof_first = b; else sof_second = b;
      end
      if (ln == 0   && h == 3)        cap[0] = oTD_DATA;
      if (ln == 0   && h == SAVS + 3) cap[1] = oTD_DATA;
      if (ln == V1A && h == SAVS + 3) cap[2] = oTD_DATA;
      if (ln == V2A && h == SAVS + 3) cap[3] = oTD_DATA;
      if (ln == V2A && h == 3)        cap[4] = oTD_DATA;
    end
    for (int l = 0; l < VL; l++) if (!vexp(l)) act_lines++;
    checks++; if (sof_n !== 2) begin errors++; $display("FAIL frame_sof_count got %0d want 2", sof_n); end
    checks++; if (sof_first !== 0 || sof_second - sof_first !== VL * HT) begin errors++; $display("FAIL frame_sof_spacing got %0d..%0d want 0..%0d", sof_first, sof_second, VL * HT); end
    checks++; if (acc !== act_lines * (HA / 2)) begin errors++; $display("FAIL frame_accepts got %0d want %0d", acc, act_lines * (HA / 2)); end
    checks++; if (cap[0] !== 8'hB6) begin errors++; $display("FAIL code_l0_eav got %h want B6", cap[0]); end
    checks++; if (cap[1] !== 8'hAB) begin errors++; $display("FAIL code_l0_sav got %h want AB", cap[1]); end
    checks++; if (cap[2] !== 8'h80) begin errors++; $display("FAIL code_act1_sav got %h want 80", cap[2]); end
    checks++; if (cap[3] !== 8'hC7) begin errors++; $display("FAIL code_act2_sav got %h want C7", cap[3]); end
    checks++; if (cap[4] !== 8'hDA) begin errors++; $display("FAIL code_act2_eav got %h want DA", cap[4]); end
    checks++; if (oUnderflow !== 1'b0) begin errors++; $display("FAIL frame_underflow got %b want 0", oUnderflow); end
  endtask

  task automatic test_underflow();
    int         b, h, ln;
    logic [7:0] exp;
    apply_reset();
    drop_line = V1A;
    drop_samp = 100;
    for (int n = 0; n < (V1A + 2) * HT; n++) begin
      drive_src();
      step();
      b = cyc - 1; h = b % HT; ln = (b / HT) % VL;
      if (h >= ACTS && !vexp(ln)) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL uf_sb_empty line %0d byte %0d got %h want queued byte", ln, h, oTD_DATA); end
        else begin
          exp = sb.pop_front();
          if (oTD_DATA !== exp) begin errors++; $display("FAIL uf_active line %0d byte %0d got %h want %h", ln, h, oTD_DATA, exp); end
        end
      end
      if (ln == V1A && h == ACTS + 199) begin
        checks++; if (oUnderflow !== 1'b0) begin errors++; $display("FAIL uf_before got %b want 0", oUnderflow); end
      end
      if (ln == V1A && h == ACTS + 200) begin
        checks++; if (oTD_DATA !== 8'h80) begin errors++; $display("FAIL uf_fill_c got %h want 80", oTD_DATA); end
        checks++; if (oUnderflow !== 1'b1) begin errors++; $display("FAIL uf_set got %b want 1", oUnderflow); end
      end
      if (ln == V1A && h == ACTS + 201) begin
        checks++; if (oTD_DATA !== 8'h10) begin errors++; $display("FAIL uf_fill_y got %h want 10", oTD_DATA); end
      end
    end
    checks++; if (oUnderflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b want 1", oUnderflow); end
  endtask

  task automatic test_clip();
    int         b, h, ln;
    logic [7:0] exp;
    apply_reset();
    clip_mode = 1'b1;
    for (int n = 0; n < (V1A + 1) * HT + 8; n++) begin
      drive_src();
      step();
      b = cyc - 1; h = b % HT; ln = (b / HT) % VL;
      if (h >= ACTS && !vexp(ln)) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL clip_sb_empty line %0d byte %0d got %h want queued byte", ln, h, oTD_DATA); end
        else begin
          exp = sb.pop_front();
          if (oTD_DATA !== exp) begin errors++; $display("FAIL clip_active line %0d byte %0d got %h want %h", ln, h, oTD_DATA, exp); end
        end
      end
      if (ln == V1A && h == ACTS) begin
        checks++; if (oTD_DATA !== 8'h01) begin errors++; $display("FAIL clip_c got %h want 01", oTD_DATA); end
      end
      if (ln == V1A && h == ACTS + 1) begin
        checks++; if (oTD_DATA !== 8'hFE) begin errors++; $display("FAIL clip_y got %h want FE", oTD_DATA); end
      end
      if (ln == V1A && h == 3) begin
        checks++; if (oTD_DATA !== 8'h9D) begin errors++; $display("FAIL clip_eav_xy got %h want 9D", oTD_DATA); end
      end
      if (ln == V1A && h == SAVS) begin
        checks++; if (oTD_DATA !== 8'hFF) begin errors++; $display("FAIL clip_sav_ff got %h want FF", oTD_DATA); end
      end
      if (ln == V1A && h == SAVS + 3) begin
        checks++; if (oTD_DATA !== 8'h80) begin errors++; $display("FAIL clip_sav_xy got %h want 80", oTD_DATA); end
      end
      if (ln == V1A + 1 && h == 0) begin
        checks++; if (oTD_DATA !== 8'hFF) begin errors++; $display("FAIL clip_next_eav_ff got %h want FF", oTD_DATA); end
      end
      if (ln == V1A + 1 && h == 3) begin
        checks++; if (oTD_DATA !== 8'h9D) begin errors++; $display("FAIL clip_next_eav_xy got %h want 9D", oTD_DATA); end
      end
    end
  endtask

  task automatic test_reset_midline();
    logic [7:0] want [4];
    want[0] = 8'hFF; want[1] = 8'h00; want[2] = 8'h00; want[3] = 8'hB6;
    apply_reset();
    for (int n = 0; n < V1A * HT + ACTS + 101; n++) begin
      drive_src();
      step();
    end
    iRST_N = 1'b0;
    #1;
    checks++; if (oTD_DATA !== 8'h80) begin errors++; $display("FAIL mid_reset_data got %h want 80", oTD_DATA); end
    checks++; if ({oF, oV, oH, oSOF} !== 4'b0110) begin errors++; $display("FAIL mid_reset_flags FVHS got %b want 0110", {oF, oV, oH, oSOF}); end
    checks++; if (sif.oReady !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got %b want 0", sif.oReady); end
    repeat (3) @(posedge iCLK);
    #1 iRST_N = 1'b1;
    clear_model();
    for (int k = 0; k < 4; k++) begin
      drive_src();
      step();
      checks++; if (oTD_DATA !== want[k]) begin errors++; $display("FAIL mid_restart_byte%0d got %h want %h", k, oTD_DATA, want[k]); end
      if (k == 0) begin
        checks++; if (oSOF !== 1'b1) begin errors++; $display("FAIL mid_restart_sof got %b want 1", oSOF); end
      end
    end
    checks++; if (oUnderflow !== 1'b0) begin errors++; $display("FAIL mid_restart_underflow got %b want 0", oUnderflow); end
  endtask

  initial begin
    sif.iDVAL  = 1'b0;
    sif.iYCbCr = '0;
    test_reset();
    test_frame();
    test_underflow();
    test_clip();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
